// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder/subtractor: a WIDTH-bit A+B+Cin or A-B computed one
// nibble per clock through a single 4-bit ripple-carry slice, with
// valid/ready handshakes on the operand and result sides.

// 4-bit ripple-carry adder slice.
module rca_4 (
   input  logic [3:0] a_i,
   input  logic [3:0] b_i,
   input  logic       cin_i,
   output logic [3:0] sum_o,
   output logic       cout_o
);

   logic [4:0] c;

   // Bit-by-bit ripple of the carry through the slice.
   always_comb begin
      c     = '0;
      sum_o = '0;
      c[0]  = cin_i;
      for (int unsigned i = 0; i < 4; i++) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
         c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
      end
   end

   assign cout_o = c[4];

endmodule

module nibble_serial_adder #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   input  logic             Sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);

   localparam int unsigned NIB  = WIDTH / 4;
   localparam int unsigned CW   = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CW-1:0] LAST = CW'(NIB - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;
   logic             amsb_q, amsb_d;
   logic             bmsb_q, bmsb_d;

   logic [3:0]       slice_sum;
   logic             slice_cout;

   rca_4 u_slice (
      .a_i    (opa_q[3:0]),
      .b_i    (opb_q[3:0]),
      .cin_i  (carry_q),
      .sum_o  (slice_sum),
      .cout_o (slice_cout)
   );

   // Next-state logic: operand capture, per-nibble shift and completion.
   always_comb begin
      state_d = state_q;
      opa_d   = opa_q;
      opb_d   = opb_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      amsb_d  = amsb_q;
      bmsb_d  = bmsb_q;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               opa_d   = A;
               opb_d   = Sub ? ~B : B;
               carry_d = Sub ? 1'b1 : Cin;
               cnt_d   = '0;
               amsb_d  = A[WIDTH-1];
               bmsb_d  = Sub ? ~B[WIDTH-1] : B[WIDTH-1];
               state_d = RUN;
            end
         end
         RUN: begin
            opa_d   = {4'b0000, opa_q[WIDTH-1:4]};
            opb_d   = {4'b0000, opb_q[WIDTH-1:4]};
            res_d   = {slice_sum, res_q[WIDTH-1:4]};
            carry_d = slice_cout;
            if (cnt_q == LAST) begin
               // Counter holds at LAST so it never wraps.
               sum_d   = {slice_sum, res_q[WIDTH-1:4]};
               cout_d  = slice_cout;
               ovf_d   = (amsb_q == bmsb_q) && (slice_sum[3] != amsb_q);
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset that discards any partial result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         amsb_q  <= 1'b0;
         bmsb_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
         amsb_q  <= amsb_d;
         bmsb_q  <= bmsb_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign Sum       = sum_q;
   assign Cout      = cout_q;
   assign Overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=32): directed operations
// push hand-computed results; a monitor checks every output transfer.
module tb_nibble_serial_adder;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Cin;
   logic         Sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] Sum;
   logic         Cout;
   logic         Overflow;

   int           total_cnt = 0;
   int           pass_cnt  = 0;
   logic [W+1:0] sb[$];

   nibble_serial_adder #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .Cin       (Cin),
      .Sub       (Sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Sum       (Sum),
      .Cout      (Cout),
      .Overflow  (Overflow)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: compare each transferred result against the scoreboard head.
   always @(negedge clk) begin
      logic [W+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_output", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("sum", Sum, e[W+1:2]);
            chk("cout", {31'd0, Cout}, {31'd0, e[1]});
            chk("overflow", {31'd0, Overflow}, {31'd0, e[0]});
         end
      end
   end

   // Issue one op, push its expected result, and check latency to out_valid.
   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic [W-1:0] es, input logic ec, input logic eo);
      int unsigned n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("accept_ready", {31'd0, in_ready}, 32'd1);
      A = a; B = b; Cin = c; Sub = s; in_valid = 1'b1;
      sb.push_back({es, ec, eo});
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("in_ready_fall", {31'd0, in_ready}, 32'd0);
      n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
      chk("latency", n, 32'd8);
   endtask

   task automatic wait_idle();
      int unsigned n;
      n = 0;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      chk("return_idle", {31'd0, in_ready}, 32'd1);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; Sub = 1'b0; out_ready = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_sum", Sum, 32'd0);
      chk("rst_cout", {31'd0, Cout}, 32'd0);
      chk("rst_ovf", {31'd0, Overflow}, 32'd0);

      issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0); wait_idle();
      issue(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0); wait_idle();
      issue(32'h7FFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h80000000, 1'b0, 1'b1); wait_idle();
      issue(32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0); wait_idle();
      issue(32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0); wait_idle();

      // Backpressure with new operands waiting.
      out_ready = 1'b0;
      issue(32'h00000001, 32'h00000001, 1'b0, 1'b0, 32'h00000002, 1'b0, 1'b0);
      A = 32'h00000003; B = 32'h00000004; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_sum", Sum, 32'h00000002);
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk); #1;
      end
      sb.push_back({32'h00000007, 1'b0, 1'b0});
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_idle_after_xfer", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_accepted", {31'd0, in_ready}, 32'd0);
      wait_idle();

      // Reset in the middle of RUN.
      A = 32'h12345678; B = 32'h11111111; Cin = 1'b0; Sub = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_sum", Sum, 32'd0);
      chk("mid_rst_cout", {31'd0, Cout}, 32'd0);
      chk("mid_rst_ovf", {31'd0, Overflow}, 32'd0);
      issue(32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0); wait_idle();

      @(posedge clk); #1;
      chk("scoreboard_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Word-wide adder/subtractor that computes a WIDTH-bit result over WIDTH/4 clock cycles, one nibble per cycle, through a single `rca_4` 4-bit ripple-carry slice. It sits between the operand source and the result consumer and uses valid/ready handshakes on both sides. It trades throughput for area wherever a full-width adder is not justified, such as multi-cycle ALU ops and address accumulation.

## Interface
- WIDTH, 32, operand and result width. Must be a multiple of 4 and at least 8.
- clk  input  1  clock. All state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands. High only in IDLE.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in. Used only when Sub=0.
- Sub  input  1  0 computes A+B+Cin; 1 computes A-B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- Sum  output  WIDTH  result.
- Cout  output  1  carry out of bit WIDTH-1. For Sub=1 this is the inverted borrow.
- Overflow  output  1  two's-complement signed overflow.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE.** in_ready=1.
  - On an edge with in_valid=1, the block latches A into opa.
  - It latches B, or ~B when Sub=1, into opb.
  - It sets carry = Sub ? 1 : Cin, clears the nibble counter and goes to RUN.
- **RUN.** Each edge does the following:
  - Feeds opa[3:0], opb[3:0] and carry into `rca_4`.
  - Shifts opa and opb right by 4.
  - Shifts the slice sum into the top nibble of a result shift register.
  - Loads the slice Cout into carry and increments the counter.
  - On the edge that processes nibble WIDTH/4-1, it does all of the above and also:
    - loads Sum from the completed result;
    - sets Cout = final slice carry;
    - sets Overflow;
    - goes to DONE.
- **Overflow.** Overflow = (A[W-1] == B'[W-1]) && (Sum[W-1] != A[W-1]).
  - B' is the post-inversion operand.
  - Both MSBs are captured at accept.
- **DONE.** out_valid=1. On an edge with out_ready=1, the block goes to IDLE.
- in_valid is ignored outside IDLE. out_ready is ignored outside DONE.
- Sum, Cout and Overflow change only on the completion edge. They keep their values through DONE and IDLE until the next completion.
- rst=1 on any edge, including mid-RUN, overrides everything:
  - state=IDLE;
  - Sum=0, Cout=0, Overflow=0;
  - out_valid=0, counter=0, carry=0.
  - A partially computed result is discarded and never presented.
- Reset values: in_ready=1 after reset, out_valid=0, Sum=0, Cout=0, Overflow=0.

## Timing
- Accept edge E0 is where in_valid && in_ready.
- Nibble k (k = 0..WIDTH/4-1) is processed on edge E(k+1).
- out_valid rises in the cycle after edge E(WIDTH/4). For WIDTH=32 that is 8 edges after accept.
- in_ready falls in the cycle after E0. It returns to 1 in the cycle after the output-transfer edge.
- If out_ready is already high when out_valid rises, the transfer takes one cycle. Back-to-back accepts are then spaced WIDTH/4+2 edges apart (10 for WIDTH=32).
- There is no combinational path from in_valid to in_ready, or from out_ready to out_valid.
- Under backpressure, out_valid, Sum, Cout and Overflow stay stable for every cycle of DONE.
- The counter is $clog2(WIDTH/4) bits wide. It terminates on compare to WIDTH/4-1 and never wraps in use.

## Test plan
All scenarios use WIDTH=32.
1. A=0x00000001, B=0x00000001, Cin=0, Sub=0 -> Sum=0x00000002, Cout=0, Overflow=0. out_valid first seen 8 edges after accept.
2. A=0xFFFFFFFF, B=0x00000001, Cin=0 -> Sum=0x00000000, Cout=1, Overflow=0. The carry ripples across all 8 nibbles.
3. A=0x7FFFFFFF, B=0x00000000, Cin=1 -> Sum=0x80000000, Cout=0, Overflow=1.
4. A=0x00000005, B=0x00000007, Sub=1, Cin=1 -> Sum=0xFFFFFFFE, Cout=0, Overflow=0. Cin is ignored. Repeat with A=7, B=5 -> Sum=0x00000002, Cout=1.
5. Backpressure: run scenario 1 with out_ready=0 for 5 cycles of DONE while in_valid=1 with new operands.
   - Required: Sum stays 0x00000002, out_valid stays 1 and in_ready stays 0 throughout.
   - Required: the new operands are accepted only in IDLE after the transfer.
6. Assert rst for one edge after 3 RUN edges of A=0x12345678, B=0x11111111.
   - Required next cycle: in_ready=1, out_valid=0, Sum=0, Cout=0, Overflow=0.
   - Required: a following op of the same operands yields Sum=0x23456789, Cout=0.
